// File: rtl/packet_tx.sv
// packet_tx: outbound packet serializer. Latches the reward-block fields on a
// start pulse and emits a type-dependent sequence of words under a
// valid/ready handshake, closing with an XOR checksum of all prior words.
module packet_tx #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [2:0]            rPacketType,
    input  logic [WORD_WIDTH-1:0] rSourceID,
    input  logic [WORD_WIDTH-1:0] rDestinationID,
    input  logic [WORD_WIDTH-1:0] rSourceHops,
    input  logic [WORD_WIDTH-1:0] rQValue,
    input  logic [WORD_WIDTH-1:0] rEnergyLeft,
    input  logic [WORD_WIDTH-1:0] rChosenCH,
    input  logic [WORD_WIDTH-1:0] rHopsFromCH,
    input  logic                  tx_ready,
    output logic [WORD_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  tx_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT                 state, stateNext;
    logic [4:0]            idx, idxNext;
    logic [4:0]            lenReg, lenNext;
    logic [2:0]            typeReg;
    logic [WORD_WIDTH-1:0] csum, csumNext;
    logic [WORD_WIDTH-1:0] dataNext;
    logic                  validNext, doneNext, errNext, loadFields;
    logic [4:0]            nextSlot;
    logic [WORD_WIDTH-1:0] slotWord;
    logic [WORD_WIDTH-1:0] headerWord;

    logic [WORD_WIDTH-1:0] srcReg, destReg, srcHopsReg, qReg, energyReg;
    logic [WORD_WIDTH-1:0] chosenReg, hopsFromReg;

    // Total word count per packet type; 0 marks an unsupported type.
    function automatic logic [4:0] lenOf(input logic [2:0] t);
        case (t)
            3'd1:    lenOf = 5'd6;
            3'd2:    lenOf = 5'd8;
            3'd3:    lenOf = 5'd6;
            3'd4:    lenOf = 5'd7;
            3'd5:    lenOf = 5'd6;
            default: lenOf = 5'd0;
        endcase
    endfunction

    assign nextSlot = idx + 5'd1;

    // Header word built from the incoming type, since it is emitted before latching completes.
    always_comb begin
        headerWord = '0;
        headerWord[WORD_WIDTH-1 -: 8] = {rPacketType, lenOf(rPacketType)};
    end

    // Payload word for the slot following the current one, per latched type.
    always_comb begin
        slotWord = '0;
        case (typeReg)
            3'd1: case (nextSlot)
                5'd1:    slotWord = srcReg;
                5'd2:    slotWord = srcHopsReg;
                5'd3:    slotWord = qReg;
                5'd4:    slotWord = energyReg;
                default: slotWord = '0;
            endcase
            3'd2: case (nextSlot)
                5'd1:    slotWord = srcReg;
                5'd2:    slotWord = srcHopsReg;
                5'd3:    slotWord = qReg;
                5'd4:    slotWord = energyReg;
                5'd5:    slotWord = chosenReg;
                5'd6:    slotWord = hopsFromReg;
                default: slotWord = '0;
            endcase
            3'd3: case (nextSlot)
                5'd1:    slotWord = srcReg;
                5'd2:    slotWord = destReg;
                5'd3:    slotWord = chosenReg;
                5'd4:    slotWord = hopsFromReg;
                default: slotWord = '0;
            endcase
            3'd4: case (nextSlot)
                5'd1:    slotWord = srcReg;
                5'd2:    slotWord = destReg;
                5'd3:    slotWord = srcHopsReg;
                5'd4:    slotWord = qReg;
                5'd5:    slotWord = energyReg;
                default: slotWord = '0;
            endcase
            3'd5: case (nextSlot)
                5'd1:    slotWord = srcReg;
                5'd2:    slotWord = destReg;
                5'd3:    slotWord = qReg;
                5'd4:    slotWord = energyReg;
                default: slotWord = '0;
            endcase
            default: slotWord = '0;
        endcase
    end

    // Next-state and next-output logic; outputs are registered one cycle later.
    always_comb begin
        stateNext  = state;
        idxNext    = idx;
        lenNext    = lenReg;
        csumNext   = csum;
        dataNext   = tx_data;
        validNext  = tx_valid;
        doneNext   = 1'b0;
        errNext    = 1'b0;
        loadFields = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    if (lenOf(rPacketType) != 5'd0) begin
                        stateNext  = SEND;
                        loadFields = 1'b1;
                        idxNext    = '0;
                        lenNext    = lenOf(rPacketType);
                        csumNext   = '0;
                        dataNext   = headerWord;
                        validNext  = 1'b1;
                    end else begin
                        errNext = 1'b1;
                    end
                end
            end
            SEND: begin
                if (tx_valid && tx_ready) begin
                    csumNext = csum ^ tx_data;
                    if (idx == lenReg - 5'd1) begin
                        stateNext = DONE;
                        validNext = 1'b0;
                        dataNext  = '0;
                        doneNext  = 1'b1;
                    end else begin
                        idxNext  = nextSlot;
                        // The checksum slot takes the accumulator including the word just accepted.
                        dataNext = (nextSlot == lenReg - 5'd1) ? csumNext : slotWord;
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
                validNext = 1'b0;
                dataNext  = '0;
            end
        endcase
    end

    // State, datapath and registered outputs; asynchronous abort on reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            idx         <= '0;
            lenReg      <= '0;
            typeReg     <= '0;
            csum        <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            srcReg      <= '0;
            destReg     <= '0;
            srcHopsReg  <= '0;
            qReg        <= '0;
            energyReg   <= '0;
            chosenReg   <= '0;
            hopsFromReg <= '0;
        end else begin
            state    <= stateNext;
            idx      <= idxNext;
            lenReg   <= lenNext;
            csum     <= csumNext;
            tx_data  <= dataNext;
            tx_valid <= validNext;
            tx_busy  <= validNext;
            tx_done  <= doneNext;
            tx_err   <= errNext;
            if (loadFields) begin
                typeReg     <= rPacketType;
                srcReg      <= rSourceID;
                destReg     <= rDestinationID;
                srcHopsReg  <= rSourceHops;
                qReg        <= rQValue;
                energyReg   <= rEnergyLeft;
                chosenReg   <= rChosenCH;
                hopsFromReg <= rHopsFromCH;
            end
        end
    end

endmodule

// File: tb/tb_packet_tx.sv
// tb_packet_tx: directed bench for packet_tx with hand-written word sequences.
module tb_packet_tx;

    logic        clk;
    logic        nrst;
    logic        en;
    logic [2:0]  rPacketType;
    logic [15:0] rSourceID, rDestinationID, rSourceHops, rQValue;
    logic [15:0] rEnergyLeft, rChosenCH, rHopsFromCH;
    logic        tx_ready;
    logic [15:0] tx_data;
    logic        tx_valid, tx_busy, tx_done, tx_err;

    int passCnt  = 0;
    int totalCnt = 0;

    packet_tx #(.WORD_WIDTH(16)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .en             (en),
        .rPacketType    (rPacketType),
        .rSourceID      (rSourceID),
        .rDestinationID (rDestinationID),
        .rSourceHops    (rSourceHops),
        .rQValue        (rQValue),
        .rEnergyLeft    (rEnergyLeft),
        .rChosenCH      (rChosenCH),
        .rHopsFromCH    (rHopsFromCH),
        .tx_ready       (tx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done),
        .tx_err         (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic setFields(input logic [15:0] s, d, sh, q, e, c, h);
        rSourceID      = s;
        rDestinationID = d;
        rSourceHops    = sh;
        rQValue        = q;
        rEnergyLeft    = e;
        rChosenCH      = c;
        rHopsFromCH    = h;
    endtask

    // Sends one packet and checks every word. w[] holds header and payload;
    // the final word is checked against the bench's XOR of the preceding words.
    // stallAt: word index where tx_ready drops for 3 cycles (-1 = none).
    // disturbAt: word index where en is re-pulsed and fields are scrambled (-1 = none).
    task automatic sendPkt(input string tag, input logic [2:0] t, input int n,
                           input logic [15:0] w [8], input int stallAt, input int disturbAt,
                           input logic [15:0] handCsum);
        logic [15:0] csum;
        logic [15:0] expWord;
        csum = '0;
        rPacketType = t;
        en = 1'b1;
        tick;
        en = 1'b0;
        for (int i = 0; i < n; i++) begin
            expWord = (i == n - 1) ? csum : w[i];
            if (i == stallAt) begin
                tx_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    check({tag, " stall valid"}, {15'd0, tx_valid}, 16'd1);
                    check({tag, " stall data"}, tx_data, expWord);
                    tick;
                end
                tx_ready = 1'b1;
            end
            if (i == disturbAt) begin
                en = 1'b1;
                rPacketType = 3'd1;
                setFields(16'hffff, 16'hffff, 16'hffff, 16'hffff, 16'hffff, 16'hffff, 16'hffff);
            end
            check({tag, " valid"}, {15'd0, tx_valid}, 16'd1);
            check({tag, " busy"}, {15'd0, tx_busy}, 16'd1);
            check({tag, " word"}, tx_data, expWord);
            csum = csum ^ tx_data;
            tick;
            en = 1'b0;
        end
        if (handCsum !== 16'h0000)
            check({tag, " hand checksum"}, w[n-1], handCsum);
        check({tag, " done"}, {15'd0, tx_done}, 16'd1);
        check({tag, " valid after"}, {15'd0, tx_valid}, 16'd0);
        check({tag, " busy after"}, {15'd0, tx_busy}, 16'd0);
        tick;
        check({tag, " done pulse"}, {15'd0, tx_done}, 16'd0);
        tick;
        check({tag, " no resend"}, {15'd0, tx_valid}, 16'd0);
    endtask

    logic [15:0] w [8];

    initial begin
        nrst = 1'b0;
        en = 1'b0;
        rPacketType = 3'd0;
        tx_ready = 1'b1;
        setFields('0, '0, '0, '0, '0, '0, '0);
        #2;
        check("rst data", tx_data, 16'h0000);
        check("rst valid", {15'd0, tx_valid}, 16'd0);
        check("rst busy", {15'd0, tx_busy}, 16'd0);
        check("rst done", {15'd0, tx_done}, 16'd0);
        check("rst err", {15'd0, tx_err}, 16'd0);
        tick;
        nrst = 1'b1;
        tick;

        // Heartbeat, ready held high; last element is a hand-computed checksum.
        setFields(16'h000c, 16'h0000, 16'h0001, 16'h0000, 16'h8000, 16'h0000, 16'h0000);
        w = '{16'h2600, 16'h000c, 16'h0001, 16'h0000, 16'h8000, 16'ha60d, 16'h0, 16'h0};
        sendPkt("hb", 3'd1, 6, w, -1, -1, 16'ha60d);

        // Heartbeat with ready stalled on word 2.
        setFields(16'h000c, 16'h0000, 16'h0001, 16'h0000, 16'h8000, 16'h0000, 16'h0000);
        sendPkt("hbstall", 3'd1, 6, w, 1, -1, 16'ha60d);

        // CH election.
        setFields(16'h0011, 16'h0099, 16'h0002, 16'h1234, 16'h00ff, 16'h0003, 16'h0002);
        w = '{16'h4800, 16'h0011, 16'h0002, 16'h1234, 16'h00ff, 16'h0003, 16'h0002, 16'h0};
        sendPkt("ch", 3'd2, 8, w, -1, -1, 16'h0000);

        // Join, data, reward with distinct field values.
        setFields(16'h0a01, 16'h0b02, 16'h0c03, 16'h0d04, 16'h0e05, 16'h0f06, 16'h1007);
        w = '{16'h6600, 16'h0a01, 16'h0b02, 16'h0f06, 16'h1007, 16'h0, 16'h0, 16'h0};
        sendPkt("join", 3'd3, 6, w, -1, -1, 16'h0000);
        w = '{16'h8700, 16'h0a01, 16'h0b02, 16'h0c03, 16'h0d04, 16'h0e05, 16'h0, 16'h0};
        sendPkt("data", 3'd4, 7, w, -1, -1, 16'h0000);
        w = '{16'ha600, 16'h0a01, 16'h0b02, 16'h0d04, 16'h0e05, 16'h0, 16'h0, 16'h0};
        sendPkt("rwd", 3'd5, 6, w, -1, -1, 16'h0000);

        // Unsupported types 0 and 7.
        rPacketType = 3'd0;
        en = 1'b1;
        tick;
        en = 1'b0;
        check("err0 pulse", {15'd0, tx_err}, 16'd1);
        check("err0 valid", {15'd0, tx_valid}, 16'd0);
        tick;
        check("err0 clear", {15'd0, tx_err}, 16'd0);
        check("err0 idle", {15'd0, tx_valid}, 16'd0);
        rPacketType = 3'd7;
        en = 1'b1;
        tick;
        en = 1'b0;
        check("err7 pulse", {15'd0, tx_err}, 16'd1);
        check("err7 valid", {15'd0, tx_valid}, 16'd0);
        tick;
        check("err7 clear", {15'd0, tx_err}, 16'd0);
        setFields(16'h000c, 16'h0000, 16'h0001, 16'h0000, 16'h8000, 16'h0000, 16'h0000);
        w = '{16'h2600, 16'h000c, 16'h0001, 16'h0000, 16'h8000, 16'ha60d, 16'h0, 16'h0};
        sendPkt("aftererr", 3'd1, 6, w, -1, -1, 16'ha60d);

        // en re-pulsed and fields scrambled mid-packet.
        setFields(16'h0a01, 16'h0b02, 16'h0c03, 16'h0d04, 16'h0e05, 16'h0f06, 16'h1007);
        w = '{16'h8700, 16'h0a01, 16'h0b02, 16'h0c03, 16'h0d04, 16'h0e05, 16'h0, 16'h0};
        sendPkt("disturb", 3'd4, 7, w, -1, 2, 16'h0000);
        check("disturb no err", {15'd0, tx_err}, 16'd0);

        // Reset asserted while word 3 is on the bus.
        setFields(16'h000c, 16'h0000, 16'h0001, 16'h0000, 16'h8000, 16'h0000, 16'h0000);
        rPacketType = 3'd1;
        en = 1'b1;
        tick;
        en = 1'b0;
        tick;
        tick;
        check("pre-rst word3", tx_data, 16'h0001);
        #2;
        nrst = 1'b0;
        #1;
        check("arst data", tx_data, 16'h0000);
        check("arst valid", {15'd0, tx_valid}, 16'd0);
        check("arst busy", {15'd0, tx_busy}, 16'd0);
        tick;
        nrst = 1'b1;
        tick;
        check("no resume", {15'd0, tx_valid}, 16'd0);
        w = '{16'h2600, 16'h000c, 16'h0001, 16'h0000, 16'h8000, 16'ha60d, 16'h0, 16'h0};
        sendPkt("fresh", 3'd1, 6, w, -1, -1, 16'ha60d);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
